io_rx_controller: RTL and testbench
===================================

IO_RX_CONTROLLER -- requirements
Module: io_rx_controller

Interface
REQ-001 The block SHALL have no parameters; image dimensions are runtime inputs.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port en, input, 1 bit: start request, and keep-alive while receiving.
REQ-005 The block SHALL have port nrows, input, 8 bits: last row index, inclusive; image height is nrows+1.
REQ-006 The block SHALL have port ncols, input, 8 bits: last column index, inclusive; image width is ncols+1.
REQ-007 The block SHALL have port din, input, 8 bits: incoming pixel byte.
REQ-008 The block SHALL have port din_valid, input, 1 bit: din holds a valid byte this cycle.
REQ-009 The block SHALL have port din_ready, output, 1 bit: the block accepts din this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame receive is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when a full frame has been written.
REQ-012 The block SHALL have port sram_ctrl, output, img_sram_ctrl_t: SRAM control (sense_en, write_en, row, col, din).

Function
REQ-013 The block SHALL implement states IDLE, RECV, FLUSH and DONE.
REQ-014 In IDLE with en=1, the block SHALL snapshot nrows/ncols into internal registers, clear row/col counters to 0 and enter RECV next cycle.
REQ-015 din_ready SHALL equal 1 only in RECV; busy SHALL equal 1 in RECV and FLUSH.
REQ-016 A byte SHALL be accepted on an edge where state=RECV, en=1 and din_valid=1; in every other case din SHALL be ignored.
REQ-017 On acceptance the block SHALL load the write stage (wr_en=1, wr_row=row, wr_col=col, wr_data=din); otherwise it SHALL clear wr_en.
REQ-018 sram_ctrl SHALL be driven combinationally from the write stage: write_en=wr_en, sense_en=~wr_en, row=wr_row, col=wr_col, din=wr_data.
REQ-019 Latency: a byte accepted at edge N SHALL appear with write_en=1 for exactly the cycle between edges N and N+1.
REQ-020 Counters SHALL be raster order; on acceptance with col<ncols_q, col SHALL increment; with col=ncols_q, col SHALL go to 0 and row SHALL increment.
REQ-021 Acceptance at row=nrows_q and col=ncols_q SHALL move the block to FLUSH; counters SHALL NOT wrap past the last pixel.
REQ-022 FLUSH SHALL last one cycle, during which the final write issues, and SHALL then move to DONE.
REQ-023 DONE SHALL assert done=1 for one cycle with busy=0, then return to IDLE regardless of en.
REQ-024 din_valid=0 in RECV SHALL stall the block with no counter change and no write.
REQ-025 Deasserting en in RECV SHALL abort: next state IDLE, no done pulse, counters cleared; a byte accepted on the previous edge SHALL still be written.
REQ-026 Changes to nrows/ncols after the start SHALL NOT affect the frame in progress.
REQ-027 nrows=ncols=0 SHALL be legal and form a 1-pixel frame.
REQ-028 Counters SHALL be 8 bits, with comparisons against the snapshot only; no 9-bit overflow path is needed.

Reset
REQ-029 When rst=1 at an edge, the block SHALL enter IDLE, clear counters, snapshots and the write stage, and drive busy=0, done=0, din_ready=0, write_en=0, sense_en=1, row=col=din=0.
REQ-030 Reset mid-frame SHALL suppress any pending write in the following cycle.

Structure
REQ-031 img_sram_ctrl_t SHALL come from the existing img_sram_pkg; the state enum (rx_state_t) SHALL be added to img_sram_pkg.
REQ-032 The block SHALL be a single module with no sub-modules; the write stage is an internal register set.

Verification
REQ-033 Bench: nrows=1, ncols=2, en held, din_valid continuous with bytes 0x10..0x15 -> writes (0,0)=0x10 .. (1,2)=0x15 each one cycle after acceptance; done pulses once, 2 cycles after the last acceptance.
REQ-034 Bench: nrows=ncols=0, single byte 0xA5 -> one write to (0,0), FLUSH, then DONE; busy is high for exactly 2 cycles.
REQ-035 Bench: 2x2 frame with din_valid toggled 1,0,1,0... -> exactly 4 writes, no write in stall cycles, addresses in raster order.
REQ-036 Bench: en dropped after 3 of 6 bytes in a 2x3 frame -> 3 writes, no done, busy=0; a new en restarts at (0,0).
REQ-037 Bench: rst asserted on the edge after an acceptance -> write_en=0 in the next cycle, state IDLE.
REQ-038 Bench: nrows changed from 1 to 5 mid-frame -> the frame ends after 2 rows as per the snapshot.

Source files
------------

// File: rtl/img_sram_pkg.sv
// Shared types for the image SRAM path: SRAM control bundle and RX FSM states.
package img_sram_pkg;

  // One-cycle SRAM command: write when write_en, otherwise sense (read) idle.
  typedef struct packed {
    logic       sense_en;
    logic       write_en;
    logic [7:0] row;
    logic [7:0] col;
    logic [7:0] din;
  } img_sram_ctrl_t;

  // Frame receive controller states.
  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StFlush,
    StDone
  } rx_state_t;

endpackage

// File: rtl/io_rx_controller.sv
// Receives a raster-ordered pixel stream and writes it into the image SRAM,
// one byte per accepted handshake, with a one-cycle registered write stage.
module io_rx_controller
  import img_sram_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [7:0]     nrows,
  input  logic [7:0]     ncols,
  input  logic [7:0]     din,
  input  logic           din_valid,
  output logic           din_ready,
  output logic           busy,
  output logic           done,
  output img_sram_ctrl_t sram_ctrl
);

  rx_state_t  state_q, state_d;
  logic [7:0] nrows_q, ncols_q;
  logic [7:0] row_q, col_q;
  logic       wr_en_q;
  logic [7:0] wr_row_q, wr_col_q, wr_data_q;

  logic accept;
  logic last_pix;

  assign accept   = (state_q == StRecv) && en && din_valid;
  assign last_pix = (row_q == nrows_q) && (col_q == ncols_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping en while receiving aborts the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en) state_d = StRecv;
      StRecv: begin
        if (!en) begin
          state_d = StIdle;
        end else if (accept && last_pix) begin
          state_d = StFlush;
        end
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Dimension snapshot, raster counters and the write stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      nrows_q   <= '0;
      ncols_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
    end else begin
      if (state_q == StIdle && en) begin
        nrows_q <= nrows;
        ncols_q <= ncols;
        row_q   <= '0;
        col_q   <= '0;
      end else if (state_q == StRecv && !en) begin
        row_q <= '0;
        col_q <= '0;
      end else if (accept && !last_pix) begin
        // Counters stop on the last pixel so they never wrap past the frame.
        if (col_q == ncols_q) begin
          col_q <= '0;
          row_q <= row_q + 8'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end

      wr_en_q <= accept;
      if (accept) begin
        wr_row_q  <= row_q;
        wr_col_q  <= col_q;
        wr_data_q <= din;
      end
    end
  end

  // Outputs: status decode and SRAM command straight from the write stage.
  always_comb begin
    din_ready          = (state_q == StRecv);
    busy               = (state_q == StRecv) || (state_q == StFlush);
    done               = (state_q == StDone);
    sram_ctrl.write_en = wr_en_q;
    sram_ctrl.sense_en = ~wr_en_q;
    sram_ctrl.row      = wr_row_q;
    sram_ctrl.col      = wr_col_q;
    sram_ctrl.din      = wr_data_q;
  end

endmodule

// File: tb/tb_io_rx_controller.sv
// Self-checking bench for io_rx_controller: directed frames plus randomized
// frames, compared every cycle against a pixel-index reference model.
module tb_io_rx_controller;
  import img_sram_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [7:0]     nrows, ncols, din;
  logic           din_valid;
  logic           din_ready, busy, done;
  img_sram_ctrl_t sram_ctrl;

  int checks = 0;
  int errors = 0;
  int n_wr, n_done, n_busy;
  logic chk_on = 1'b0;

  io_rx_controller dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .nrows     (nrows),
    .ncols     (ncols),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .busy      (busy),
    .done      (done),
    .sram_ctrl (sram_ctrl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is a count of pixels; address = index div/mod width.
  logic       m_recv, m_flush, m_done, m_wr;
  int         m_pix, m_total;
  logic [7:0] m_nc, m_wrow, m_wcol, m_wdat;

  always @(posedge clk) begin
    if (rst) begin
      m_recv <= 1'b0; m_flush <= 1'b0; m_done <= 1'b0; m_wr <= 1'b0;
      m_pix <= 0; m_total <= 1; m_nc <= '0;
      m_wrow <= '0; m_wcol <= '0; m_wdat <= '0;
    end else begin
      m_flush <= 1'b0;
      m_done  <= m_flush;
      m_wr    <= 1'b0;
      if (!m_recv && !m_flush && !m_done && en) begin
        m_recv  <= 1'b1;
        m_pix   <= 0;
        m_total <= (int'(nrows) + 1) * (int'(ncols) + 1);
        m_nc    <= ncols;
      end else if (m_recv) begin
        if (!en) begin
          m_recv <= 1'b0;
        end else if (din_valid) begin
          m_wr   <= 1'b1;
          m_wrow <= 8'(m_pix / (int'(m_nc) + 1));
          m_wcol <= 8'(m_pix % (int'(m_nc) + 1));
          m_wdat <= din;
          m_pix  <= m_pix + 1;
          if (m_pix + 1 == m_total) begin
            m_recv  <= 1'b0;
            m_flush <= 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 32'(busy), 32'(m_recv | m_flush));
      check("done", 32'(done), 32'(m_done));
      check("din_ready", 32'(din_ready), 32'(m_recv));
      check("write_en", 32'(sram_ctrl.write_en), 32'(m_wr));
      check("sense_en", 32'(sram_ctrl.sense_en), 32'(!m_wr));
      if (m_wr) begin
        check("wr_row", 32'(sram_ctrl.row), 32'(m_wrow));
        check("wr_col", 32'(sram_ctrl.col), 32'(m_wcol));
        check("wr_din", 32'(sram_ctrl.din), 32'(m_wdat));
      end
      if (sram_ctrl.write_en) n_wr++;
      if (done) n_done++;
      if (busy) n_busy++;
    end
  end

  // mode: 0 valid always, 1 valid alternating, 2 valid random.
  // base >= 0 gives bytes base+idx, else random bytes.
  task automatic send_frame(input logic [7:0] nr, input logic [7:0] nc, input int mode,
                            input int base, input int abort_at, input int chg_at,
                            input logic [7:0] nr_new);
    int   total, idx, budget, phase;
    logic acc;
    total  = (int'(nr) + 1) * (int'(nc) + 1);
    idx    = 0;
    budget = 4000;
    phase  = 0;
    nrows  = nr;
    ncols  = nc;
    en     = 1'b1;
    while (idx < total && budget > 0) begin
      din = (base >= 0) ? 8'(base + idx) : 8'($urandom);
      case (mode)
        0:       din_valid = 1'b1;
        1:       din_valid = (phase % 2 == 0);
        default: din_valid = 1'($urandom_range(1));
      endcase
      @(negedge clk);
      acc = din_ready && din_valid;
      @(posedge clk);
      #1;
      budget--;
      phase++;
      if (acc) idx++;
      if (idx == chg_at) nrows = nr_new;
      if (idx == abort_at) break;
    end
    check("frame_budget", 32'(budget > 0), 32'd1);
    en        = 1'b0;
    din_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_wr = 0; n_done = 0; n_busy = 0;
  endtask

  initial begin
    int   waited;
    logic [7:0] rnr, rnc;
    rst = 1'b1; en = 1'b0; nrows = '0; ncols = '0; din = '0; din_valid = 1'b0;
    clear_counts();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd0);
    check("rst_write_en", 32'(sram_ctrl.write_en), 32'd0);
    check("rst_sense_en", 32'(sram_ctrl.sense_en), 32'd1);
    check("rst_addr_data", {8'd0, sram_ctrl.row, sram_ctrl.col, sram_ctrl.din}, 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;
    @(posedge clk);
    #1;

    // 2x3 frame, continuous bytes 0x10..0x15.
    clear_counts();
    send_frame(8'd1, 8'd2, 0, 'h10, -1, -1, 8'd0);
    check("f23_writes", 32'(n_wr), 32'd6);
    check("f23_done", 32'(n_done), 32'd1);

    // Single-pixel frame.
    clear_counts();
    send_frame(8'd0, 8'd0, 0, 'hA5, -1, -1, 8'd0);
    check("px1_writes", 32'(n_wr), 32'd1);
    check("px1_busy_cycles", 32'(n_busy), 32'd2);
    check("px1_done", 32'(n_done), 32'd1);

    // 2x2 frame with alternating valid.
    clear_counts();
    send_frame(8'd1, 8'd1, 1, -1, -1, -1, 8'd0);
    check("alt_writes", 32'(n_wr), 32'd4);
    check("alt_done", 32'(n_done), 32'd1);

    // Abort after 3 of 6 bytes, then restart.
    clear_counts();
    send_frame(8'd1, 8'd2, 0, 'h40, 3, -1, 8'd0);
    check("abort_writes", 32'(n_wr), 32'd3);
    check("abort_done", 32'(n_done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    clear_counts();
    send_frame(8'd1, 8'd2, 0, 'h60, -1, -1, 8'd0);
    check("restart_writes", 32'(n_wr), 32'd6);
    check("restart_done", 32'(n_done), 32'd1);

    // Reset on the edge after an acceptance.
    nrows = 8'd3; ncols = 8'd3; en = 1'b1; din = 8'h77; din_valid = 1'b1;
    waited = 0;
    while (!din_ready && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("rst_wait_ready", 32'(din_ready), 32'd1);
    @(posedge clk);
    #1;
    check("pre_rst_write_en", 32'(sram_ctrl.write_en), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_write_en", 32'(sram_ctrl.write_en), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_ready", 32'(din_ready), 32'd0);
    rst = 1'b0; en = 1'b0; din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // nrows changes mid-frame; snapshot governs.
    clear_counts();
    send_frame(8'd1, 8'd1, 0, 'h80, -1, 1, 8'd5);
    check("snap_writes", 32'(n_wr), 32'd4);
    check("snap_done", 32'(n_done), 32'd1);

    // Randomized frames.
    for (int k = 0; k < 8; k++) begin
      rnr = 8'($urandom_range(3));
      rnc = 8'($urandom_range(3));
      clear_counts();
      send_frame(rnr, rnc, 2, -1, -1, -1, 8'd0);
      check("rnd_writes", 32'(n_wr), (32'(rnr) + 1) * (32'(rnc) + 1));
      check("rnd_done", 32'(n_done), 32'd1);
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
